sc_spi_bufctl: RTL and testbench

SC_SPI_BUFCTL -- requirements
Module: sc_spi_bufctl

---
 rtl/sc_spi_bufctl.sv | 114 +++++++++++
 tb/tb_sc_spi_bufctl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_spi_bufctl.sv
// Host-side TX/RX word buffers and transfer sequencer for the SPI protocol engine.
// The host fills TX words while idle, pulses GO, and reads captured RX words back.
module sc_spi_bufctl #(
  parameter int DEPTH = 16
) (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic        BWEN,
  input  logic [3:0]  BWADDR,
  input  logic [31:0] BWDATA,
  input  logic        BREN,
  input  logic [3:0]  BRADDR,
  output logic [31:0] BRDATA,
  input  logic        GO,
  output logic        BUSY,
  output logic        DONE,
  output logic        WERR,
  output logic [4:0]  RXCNT,
  output logic        SPISTART,
  input  logic        SPIBUSY,
  input  logic [3:0]  TXDPT,
  output logic [31:0] TXDATA,
  input  logic [31:0] RXDATA,
  input  logic        RXVALID,
  input  logic [3:0]  RXDPT
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RUN,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        busy_dec;
  logic        done_dec;
  logic        start_dec;
  logic        rx_counting;
  logic        go_accept;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; that is also what gives the RX read its pre-write data.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy_dec  = 1'b1;
    done_dec  = 1'b0;
    start_dec = 1'b0;
    case (state)
      IDLE: begin
        busy_dec = 1'b0;
        if (GO) state_nxt = REQ;
      end
      REQ: begin
        start_dec = 1'b1;
        if (SPIBUSY) state_nxt = RUN;
      end
      RUN: begin
        if (!SPIBUSY) state_nxt = FIN;
      end
      FIN: begin
        done_dec  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the state flop only, so reset clears them without a clock.
  assign BUSY        = busy_dec;
  assign DONE        = done_dec;
  assign SPISTART    = start_dec;
  assign go_accept   = (state == IDLE) && GO;
  assign rx_counting = (state == RUN) || (state == FIN);

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      WERR   <= 1'b0;
      RXCNT  <= 5'd0;
      BRDATA <= 32'd0;
    end else begin
      if (go_accept)          WERR <= 1'b0;
      else if (BWEN && BUSY)  WERR <= 1'b1;

      if (go_accept)
        RXCNT <= 5'd0;
      else if (RXVALID && rx_counting && (RXCNT != 5'd16))
        RXCNT <= RXCNT + 5'd1;

      if (BREN) BRDATA <= rx_mem[BRADDR];
    end
  end

  // NOTE: the buffer arrays are deliberately left out of reset; their contents
  // after reset are undefined and software must rewrite them.
  always_ff @(posedge SPICLK) begin
    if (BWEN && (state == IDLE)) tx_mem[BWADDR] <= BWDATA;
    if (RXVALID)                 rx_mem[RXDPT]  <= RXDATA;
  end

  // The engine samples TXDATA in the same cycle it moves TXDPT.
  assign TXDATA = tx_mem[TXDPT];

endmodule

// File: tb/tb_sc_spi_bufctl.sv
// Self-checking bench for sc_spi_bufctl: drives host and engine sides and
// compares against a buffer/count model derived from the transfer rules.
module tb_sc_spi_bufctl;

  logic        SPICLK = 1'b0;
  logic        SYSRSTB;
  logic        BWEN;
  logic [3:0]  BWADDR;
  logic [31:0] BWDATA;
  logic        BREN;
  logic [3:0]  BRADDR;
  logic [31:0] BRDATA;
  logic        GO;
  logic        BUSY;
  logic        DONE;
  logic        WERR;
  logic [4:0]  RXCNT;
  logic        SPISTART;
  logic        SPIBUSY;
  logic [3:0]  TXDPT;
  logic [31:0] TXDATA;
  logic [31:0] RXDATA;
  logic        RXVALID;
  logic [3:0]  RXDPT;

  sc_spi_bufctl #(.DEPTH(16)) dut (
    .SPICLK(SPICLK), .SYSRSTB(SYSRSTB),
    .BWEN(BWEN), .BWADDR(BWADDR), .BWDATA(BWDATA),
    .BREN(BREN), .BRADDR(BRADDR), .BRDATA(BRDATA),
    .GO(GO), .BUSY(BUSY), .DONE(DONE), .WERR(WERR), .RXCNT(RXCNT),
    .SPISTART(SPISTART), .SPIBUSY(SPIBUSY),
    .TXDPT(TXDPT), .TXDATA(TXDATA),
    .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT)
  );

  always #5 SPICLK = ~SPICLK;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  // Reference model: buffer images plus the two host-visible status values.
  logic [31:0] m_tx [16];
  logic [31:0] m_rx [16];
  int          m_rxcnt;
  bit          m_werr;

  always @(negedge SPICLK) if (DONE === 1'b1) done_cnt++;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge SPICLK);
      #1;
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    BWEN = 1'b1; BWADDR = a; BWDATA = d;
    cyc();
    BWEN = 1'b0;
    m_tx[a] = d;
  endtask

  task automatic rx_strobe(input logic [3:0] p, input logic [31:0] d, input bit counting);
    RXVALID = 1'b1; RXDPT = p; RXDATA = d;
    cyc();
    RXVALID = 1'b0;
    m_rx[p] = d;
    if (counting && m_rxcnt < 16) m_rxcnt++;
  endtask

  task automatic host_read(input logic [3:0] a);
    BREN = 1'b1; BRADDR = a;
    cyc();
    BREN = 1'b0;
  endtask

  task automatic begin_transfer();
    GO = 1'b1;
    cyc();
    GO = 1'b0;
    m_rxcnt = 0;
    m_werr  = 1'b0;
  endtask

  task automatic test_reset();
    SYSRSTB = 1'b0; BWEN = 1'b0; BWADDR = '0; BWDATA = '0; BREN = 1'b0; BRADDR = '0;
    GO = 1'b0; SPIBUSY = 1'b0; TXDPT = '0; RXDATA = '0; RXVALID = 1'b0; RXDPT = '0;
    m_rxcnt = 0; m_werr = 1'b0;
    #12;
    checks++;
    if ({BUSY, DONE, SPISTART, WERR} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {BUSY, DONE, SPISTART, WERR});
    end
    checks++;
    if (RXCNT !== 5'd0) begin errors++; $display("FAIL reset_rxcnt got %0d want 0", RXCNT); end
    checks++;
    if (BRDATA !== 32'd0) begin errors++; $display("FAIL reset_brdata got %h want 0", BRDATA); end
    @(negedge SPICLK);
    SYSRSTB = 1'b1;
    cyc();
  endtask

  task automatic test_tx_transfer();
    int d0;
    for (int i = 0; i < 16; i++) host_write(4'(i), $urandom);
    host_write(4'd0, 32'hA5A5_0001);
    host_write(4'd1, 32'h5A5A_0002);
    for (int i = 0; i < 16; i++) begin
      TXDPT = 4'(i); #1;
      checks++;
      if (TXDATA !== m_tx[i]) begin
        errors++; $display("FAIL txdata_idle[%0d] got %h want %h", i, TXDATA, m_tx[i]);
      end
    end
    TXDPT = 4'd0;
    begin_transfer();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({SPISTART, BUSY} !== 2'b11) begin
        errors++; $display("FAIL req_start got %b want 11", {SPISTART, BUSY});
      end
      cyc();
    end
    SPIBUSY = 1'b1;
    cyc();
    checks++;
    if ({SPISTART, BUSY} !== 2'b01) begin
      errors++; $display("FAIL run_start got %b want 01", {SPISTART, BUSY});
    end
    for (int k = 0; k < 40; k++) begin
      TXDPT = (k < 20) ? 4'd0 : 4'd1; #1;
      checks++;
      if (TXDATA !== m_tx[TXDPT] || DONE !== 1'b0) begin
        errors++; $display("FAIL run_txdata[%0d] got %h/%b want %h/0", k, TXDATA, DONE, m_tx[TXDPT]);
      end
      cyc();
    end
    TXDPT = 4'd0;
    d0 = done_cnt;
    SPIBUSY = 1'b0;
    cyc();
    checks++;
    if ({DONE, BUSY} !== 2'b11) begin errors++; $display("FAIL fin_done got %b want 11", {DONE, BUSY}); end
    cyc();
    checks++;
    if ({DONE, BUSY} !== 2'b00) begin errors++; $display("FAIL idle_after got %b want 00", {DONE, BUSY}); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_rx_capture();
    begin_transfer();
    SPIBUSY = 1'b1;
    cyc();
    rx_strobe(4'd0, 32'h1234_5678, 1'b1);
    cyc(2);
    rx_strobe(4'd1, 32'h9ABC_DEF0, 1'b1);
    SPIBUSY = 1'b0;
    cyc(2);
    checks++;
    if (RXCNT !== 5'(m_rxcnt)) begin errors++; $display("FAIL rx_count got %0d want %0d", RXCNT, m_rxcnt); end
    host_read(4'd1);
    checks++;
    if (BRDATA !== m_rx[1]) begin errors++; $display("FAIL rx_read1 got %h want %h", BRDATA, m_rx[1]); end
    BRADDR = 4'd0;
    cyc(2);
    checks++;
    if (BRDATA !== m_rx[1]) begin errors++; $display("FAIL rx_hold got %h want %h", BRDATA, m_rx[1]); end
    host_read(4'd0);
    checks++;
    if (BRDATA !== m_rx[0]) begin errors++; $display("FAIL rx_read0 got %h want %h", BRDATA, m_rx[0]); end
  endtask

  task automatic test_rx_idle();
    logic [3:0]  p;
    logic [31:0] d;
    p = 4'($urandom_range(2, 15));
    d = $urandom;
    rx_strobe(p, d, 1'b0);
    checks++;
    if (RXCNT !== 5'(m_rxcnt)) begin errors++; $display("FAIL rx_idle_count got %0d want %0d", RXCNT, m_rxcnt); end
    host_read(p);
    checks++;
    if (BRDATA !== m_rx[p]) begin errors++; $display("FAIL rx_idle_data got %h want %h", BRDATA, m_rx[p]); end
  endtask

  task automatic test_werr();
    begin_transfer();
    SPIBUSY = 1'b1;
    cyc();
    BWEN = 1'b1; BWADDR = 4'd0; BWDATA = 32'hFFFF_FFFF;
    cyc();
    BWEN = 1'b0;
    m_werr = 1'b1;
    checks++;
    if (WERR !== m_werr) begin errors++; $display("FAIL werr_set got %b want %b", WERR, m_werr); end
    TXDPT = 4'd0; #1;
    checks++;
    if (TXDATA !== m_tx[0]) begin errors++; $display("FAIL werr_nowrite got %h want %h", TXDATA, m_tx[0]); end
    SPIBUSY = 1'b0;
    cyc(3);
    checks++;
    if ({WERR, BUSY} !== {m_werr, 1'b0}) begin
      errors++; $display("FAIL werr_sticky got %b want %b0", {WERR, BUSY}, m_werr);
    end
    begin_transfer();
    checks++;
    if (WERR !== m_werr) begin errors++; $display("FAIL werr_clear got %b want %b", WERR, m_werr); end
    SPIBUSY = 1'b1;
    cyc(2);
    SPIBUSY = 1'b0;
    cyc(3);
  endtask

  task automatic test_go_ignored_saturation();
    int d0;
    d0 = done_cnt;
    begin_transfer();
    GO = 1'b1;
    cyc();
    GO = 1'b0;
    checks++;
    if ({SPISTART, BUSY} !== 2'b11) begin errors++; $display("FAIL go_in_req got %b want 11", {SPISTART, BUSY}); end
    SPIBUSY = 1'b1;
    cyc();
    GO = 1'b1;
    cyc();
    GO = 1'b0;
    for (int k = 0; k < 17; k++) begin
      rx_strobe(4'($urandom_range(0, 15)), $urandom, 1'b1);
      checks++;
      if (RXCNT !== 5'(m_rxcnt)) begin
        errors++; $display("FAIL rx_sat[%0d] got %0d want %0d", k, RXCNT, m_rxcnt);
      end
    end
    SPIBUSY = 1'b0;
    cyc(5);
    checks++;
    if (BUSY !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL go_ignored busy %b dones %0d want 0 and 1", BUSY, done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      host_read(a);
      checks++;
      if (BRDATA !== m_rx[a]) begin errors++; $display("FAIL rx_rand[%0d] got %h want %h", a, BRDATA, m_rx[a]); end
    end
  endtask

  task automatic test_go_with_bwen();
    logic [3:0]  a;
    logic [31:0] d;
    a = 4'($urandom_range(0, 15));
    d = $urandom;
    GO = 1'b1; BWEN = 1'b1; BWADDR = a; BWDATA = d;
    cyc();
    GO = 1'b0; BWEN = 1'b0;
    m_tx[a] = d; m_rxcnt = 0; m_werr = 1'b0;
    checks++;
    if ({BUSY, WERR} !== {1'b1, m_werr} || RXCNT !== 5'(m_rxcnt)) begin
      errors++; $display("FAIL go_bwen busy/werr %b rxcnt %0d want 1%b %0d", {BUSY, WERR}, RXCNT, m_werr, m_rxcnt);
    end
    TXDPT = a; #1;
    checks++;
    if (TXDATA !== m_tx[a]) begin errors++; $display("FAIL go_bwen_write got %h want %h", TXDATA, m_tx[a]); end
    SPIBUSY = 1'b1;
    cyc(2);
    SPIBUSY = 1'b0;
    cyc(3);
  endtask

  task automatic test_read_collision();
    logic [3:0] k;
    k = 4'($urandom_range(0, 15));
    rx_strobe(k, 32'h1111_1111, 1'b0);
    BREN = 1'b1; BRADDR = k;
    RXVALID = 1'b1; RXDPT = k; RXDATA = 32'h2222_2222;
    cyc();
    BREN = 1'b0; RXVALID = 1'b0;
    checks++;
    if (BRDATA !== m_rx[k]) begin errors++; $display("FAIL collide_old got %h want %h", BRDATA, m_rx[k]); end
    m_rx[k] = 32'h2222_2222;
    host_read(k);
    checks++;
    if (BRDATA !== m_rx[k]) begin errors++; $display("FAIL collide_new got %h want %h", BRDATA, m_rx[k]); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit seen;
    d0 = done_cnt;
    begin_transfer();
    SPIBUSY = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) rx_strobe(4'(k), $urandom | 32'h1, 1'b1);
    BWEN = 1'b1; BWADDR = 4'd3; BWDATA = $urandom;
    cyc();
    BWEN = 1'b0;
    m_werr = 1'b1;
    host_read(4'd0);
    checks++;
    if ({WERR, RXCNT} !== {m_werr, 5'(m_rxcnt)} || BRDATA !== m_rx[0]) begin
      errors++; $display("FAIL pre_reset werr/rxcnt %b/%0d brdata %h want %b/%0d %h",
                         WERR, RXCNT, BRDATA, m_werr, m_rxcnt, m_rx[0]);
    end
    #2;
    SYSRSTB = 1'b0;
    #1;
    m_rxcnt = 0; m_werr = 1'b0;
    checks++;
    if ({BUSY, DONE, SPISTART, WERR} !== 4'b0000 || RXCNT !== 5'd0 || BRDATA !== 32'd0) begin
      errors++; $display("FAIL async_reset flags %b rxcnt %0d brdata %h want 0000 0 0",
                         {BUSY, DONE, SPISTART, WERR}, RXCNT, BRDATA);
    end
    SPIBUSY = 1'b0;
    cyc(2);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL reset_no_done got %0d want 0", done_cnt - d0); end
    SYSRSTB = 1'b1;
    cyc();
    begin_transfer();
    checks++;
    if (SPISTART !== 1'b1) begin errors++; $display("FAIL restart_req got %b want 1", SPISTART); end
    SPIBUSY = 1'b1;
    cyc(5);
    SPIBUSY = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      cyc();
      if (DONE === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL restart_done timeout got no DONE want DONE within 8 cycles"); end
    cyc();
    checks++;
    if (BUSY !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL restart_end busy %b dones %0d want 0 and 1", BUSY, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_tx_transfer();
    test_rx_capture();
    test_rx_idle();
    test_werr();
    test_go_ignored_saturation();
    test_go_with_bwen();
    test_read_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
